adder_checker: RTL
==================

# adder_checker

Synthesizable self-checking monitor that sits on the far side of the 8-bit registered adder and consumes its operands and result. It recomputes the expected sum and aligns it to the adder's pipeline latency. It compares every valid result and counts checks and mismatches, then reports pass/fail once a programmed number of vectors has been checked. It replaces the open-loop random stimulus loop with an in-design scoreboard usable in simulation and on FPGA.

## Interface
Parameters:
- WIDTH, 8, operand width; sum is WIDTH+1 bits.
- LATENCY, 1, adder input-sample-to-output latency in clock edges; legal 1..8.
- NUM_VECTORS, 1001, vectors accepted per run.
- CNT_W, 16, width of check and error counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  pulse; begins a run from IDLE or DONE.
- valid  in  1  a/b presented to the adder this cycle are a vector.
- a  in  WIDTH  operand a, same signal driving the adder.
- b  in  WIDTH  operand b, same signal driving the adder.
- sum  in  WIDTH+1  adder output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0 && chk_cnt==NUM_VECTORS.
- err_flag  out  1  one-cycle pulse per mismatch.
- chk_cnt  out  CNT_W  results compared this run.
- err_cnt  out  CNT_W  mismatches this run.

Reset value of every output is 0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN on the edge that accepts vector NUM_VECTORS.
  - DRAIN→DONE after LATENCY edges.
  - DONE→RUN on start.
- Entering RUN clears chk_cnt, err_cnt, the issued counter and the delay line.
- start in RUN or DRAIN is ignored.
- In RUN, on each edge with valid=1:
  - exp = {1'b0,a} + {1'b0,b}, WIDTH+1 bits, no truncation.
  - exp is pushed with a tag bit into the LATENCY-deep delay line.
  - The issued counter increments.
- valid=0 pushes an empty slot.
- In IDLE, DRAIN and DONE, valid is ignored and only empty slots are pushed.
- At each edge where the delay-line output slot is tagged:
  - chk_cnt increments.
  - If sum != exp, err_cnt increments and err_flag asserts for the next cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous start and a tagged slot in DONE cannot occur, because the line is empty after DRAIN.

## Timing
- Operands sampled at edge k are compared against sum sampled at edge k+LATENCY. This matches a DUT that registers inputs and output with total latency LATENCY.
- busy rises the cycle after the start edge.
- done and pass are valid the cycle after the last DRAIN edge and hold until the next start or reset.
- err_flag and the counters are registered. They update on the compare edge and are visible in the following cycle.
- Reset mid-run: asynchronous clear of state (to IDLE), counters, delay line and outputs. No partial result is reported.

## Configuration
- ADDER_CHECKER_FIRST_ERR_EN defined: adds outputs first_err_a (WIDTH), first_err_b (WIDTH), first_err_sum (WIDTH+1) and first_err_exp (WIDTH+1).
  - To support this, the delay line also carries a and b.
  - The outputs latch on the first mismatch of a run, hold until the next start, and reset to 0.
- Undefined: those ports and the extra delay-line storage are absent. All other behaviour is identical.

## Structure
- Shared package adder_checker_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the MAX_LATENCY=8 constant;
  - a function computing the WIDTH+1 expected sum.
- One sub-module, adder_checker_dly: a parameterized LATENCY-stage shift register of {tag, payload} with async active-low reset and synchronous clear.
- The top level holds the FSM, counters and compare.

## Test plan
- Reset, then start. Drive LATENCY=1, a=8'hFF, b=8'h01, correct sum=9'h100, NUM_VECTORS=1 → chk_cnt=1, err_cnt=0, done=1, pass=1.
- Same vector with sum forced to 9'h0FF → err_flag pulses once, err_cnt=1, pass=0. With the macro: first_err_exp=9'h100, first_err_sum=9'h0FF.
- 1001 random vectors, operands shifted right by 2, correct adder, valid deasserted every 3rd cycle → done after the last tagged compare plus drain, chk_cnt=1001, err_cnt=0, pass=1.
- Reset pulsed after 10 vectors → all outputs 0 and state IDLE. A new start then completes a full 1001-vector run with pass=1.
- start pulsed mid-RUN → ignored, and chk_cnt still ends at NUM_VECTORS.
- CNT_W=4, NUM_VECTORS=20, every result wrong → err_cnt saturates at 15 and chk_cnt at 15; pass=0.

Source files
------------

// File: rtl/adder_checker_pkg.sv
// Shared types and helpers for the adder_checker scoreboard.
// Widths are bounded by MAX_WIDTH so one sum function serves every WIDTH.
package adder_checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int MAX_LATENCY = 8;
  localparam int MAX_WIDTH   = 32;

  function automatic logic [MAX_WIDTH:0] calc_exp(input logic [MAX_WIDTH-1:0] x,
                                                  input logic [MAX_WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/adder_checker_dly.sv
// LATENCY-stage shift register of {tag, payload} aligning expected results
// with the adder output; clr empties every slot synchronously.
module adder_checker_dly #(
  parameter int LATENCY = 1,
  parameter int DW      = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_tag,
  input  logic [DW-1:0] in_data,
  output logic          out_tag,
  output logic [DW-1:0] out_data
);

  logic [DW:0] line_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= {in_tag, in_data};
      for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign out_tag  = line_q[LATENCY-1][DW];
  assign out_data = line_q[LATENCY-1][DW-1:0];

endmodule

// File: rtl/adder_checker.sv
// In-design scoreboard for the registered adder: FSM, counters and compare.
// Define ADDER_CHECKER_FIRST_ERR_EN to capture operands of the first mismatch.
module adder_checker
  import adder_checker_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 1001,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  ,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_sum,
  output logic [WIDTH:0]   first_err_exp
`endif
);

  localparam int EW    = WIDTH + 1;
  localparam int ISS_W = $clog2(NUM_VECTORS + 1);
  localparam int DRN_W = $clog2(MAX_LATENCY);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  localparam int DW = EW + 2*WIDTH;
`else
  localparam int DW = EW;
`endif

  state_t           state_q, state_d;
  logic [ISS_W-1:0] issued_q;
  logic [DRN_W-1:0] drain_q;
  logic             run_clr, accept, last_accept, mismatch;
  logic [EW-1:0]    exp_now, line_exp;
  logic [DW-1:0]    line_in, line_data;
  logic             line_tag;

  assign run_clr     = start && (state_q == IDLE || state_q == DONE);
  assign accept      = (state_q == RUN) && valid;
  assign last_accept = accept && (issued_q == ISS_W'(NUM_VECTORS - 1));
  assign exp_now     = EW'(calc_exp(MAX_WIDTH'(a), MAX_WIDTH'(b)));

`ifdef ADDER_CHECKER_FIRST_ERR_EN
  assign line_in  = {exp_now, a, b};
  assign line_exp = line_data[DW-1 -: EW];
`else
  assign line_in  = exp_now;
  assign line_exp = line_data;
`endif

  adder_checker_dly #(.LATENCY(LATENCY), .DW(DW)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (run_clr),
    .in_tag   (accept),
    .in_data  (line_in),
    .out_tag  (line_tag),
    .out_data (line_data)
  );

  assign mismatch = line_tag && (sum != line_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q == DRN_W'(LATENCY - 1)) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pass = done && (err_cnt == '0) && (32'(chk_cnt) == NUM_VECTORS);

  // Drain length is counted from the edge that accepted the last vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                drain_q <= '0;
    else if (state_q == DRAIN) drain_q <= drain_q + DRN_W'(1);
    else                       drain_q <= '0;
  end

  // Counters saturate rather than wrap so an overflowed run can never pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      issued_q <= '0;
    end else if (run_clr) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      issued_q <= '0;
    end else begin
      err_flag <= mismatch;
      if (line_tag && chk_cnt != '1) chk_cnt  <= chk_cnt + CNT_W'(1);
      if (mismatch && err_cnt != '1) err_cnt  <= err_cnt + CNT_W'(1);
      if (accept)                    issued_q <= issued_q + ISS_W'(1);
    end
  end

`ifdef ADDER_CHECKER_FIRST_ERR_EN
  logic first_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen    <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_sum <= '0;
      first_err_exp <= '0;
    end else if (run_clr) begin
      first_seen    <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_sum <= '0;
      first_err_exp <= '0;
    end else if (mismatch && !first_seen) begin
      first_seen    <= 1'b1;
      first_err_a   <= line_data[2*WIDTH-1 -: WIDTH];
      first_err_b   <= line_data[WIDTH-1:0];
      first_err_sum <= sum;
      first_err_exp <= line_exp;
    end
  end
`endif

endmodule
